apb3_master: RTL and testbench

- APB3 initiator: converts a simple command/response handshake from fabric logic into compliant APB3 transfers.
- Used to drive the existing APB3 peripheral bank (RSA, neopixel, servo register maps) from fabric-side engines and test sequencers without going through the MSS.
- Handles one transfer at a time: SETUP/ACCESS sequencing, PREADY wait states, PSLVERR capture, and a stall timeout.

---
 rtl/apb3_master.sv | 176 +++++++++++++++++
 tb/tb_apb3_master.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_master.sv
// ---------------------------------------------------------------------------
// apb3_master
//
// APB3 initiator. Turns a command/response handshake from fabric logic into
// APB3 transfers, one at a time: a single SETUP cycle, then ACCESS until the
// slave raises PREADY or the stall timeout expires.
//
// Parameters
//   ADDR_WIDTH      width of PADDR / cmd_addr
//   DATA_WIDTH      width of PWDATA / PRDATA / command and response data
//   TIMEOUT_CYCLES  consecutive PREADY-low ACCESS cycles before the transfer
//                   is forcibly ended (0 = never time out)
//
// Ports
//   PCLK, PRESETN   clock (rising edge) and async active-low reset
//   cmd_valid/ready command handshake; ready only in IDLE
//   cmd_write       1 = write, 0 = read
//   cmd_addr        target address
//   cmd_wdata       write data (ignored for reads)
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       read data (0 for writes and timeouts)
//   rsp_err         PSLVERR sampled high, or timeout
//   rsp_timeout     transfer ended by the timeout
//   busy            high in SETUP or ACCESS
//   PSEL..PSLVERR   APB3 master-side bus signals
// ---------------------------------------------------------------------------
module apb3_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response side
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    // APB3 bus
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    // The counter holds the number of PREADY-low ACCESS cycles already
    // completed, so the transfer expires in the ACCESS cycle where the count
    // equals TIMEOUT_CYCLES-1 and PREADY is still low.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_WAIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                r_state;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_wait_cnt;

    // NOTE: every register here, bus outputs included, sits on the async
    // reset so PSEL/PENABLE drop the moment PRESETN falls, not at the next edge.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            r_state       <= ST_IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_busy        <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // sees the pre-edge register values regardless of statement order.
            r_rsp_valid <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        // Reads leave PWDATA at the last written value.
                        if (cmd_write) begin
                            r_pwdata <= cmd_wdata;
                        end
                        r_psel     <= 1'b1;
                        r_penable  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_wait_cnt <= '0;
                        r_state    <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    // PREADY is tested first so a completion in the expiry
                    // cycle is reported as a normal transfer.
                    if (PREADY) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
                        r_rsp_err     <= PSLVERR;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else if (TIMEOUT_EN && (r_wait_cnt == LAST_WAIT)) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_busy        <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else if (TIMEOUT_EN) begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Ready depends on state alone, never on cmd_valid.
    assign cmd_ready   = (r_state == ST_IDLE);

    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PADDR       = r_paddr;
    assign PWDATA      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = r_busy;

endmodule

// File: tb/tb_apb3_master.sv
// ---------------------------------------------------------------------------
// tb_apb3_master
//
// Bench for apb3_master with TIMEOUT_CYCLES = 16. A behavioural APB slave
// answers each transfer after a programmed number of wait states with a
// programmed PSLVERR, driving junk on PRDATA/PSLVERR while not ready. The
// expected response of every command is derived from the protocol rules:
// latency, SETUP/ACCESS cycle counts, read data from a shadow memory, and
// the error/timeout flags.
// ---------------------------------------------------------------------------
module tb_apb3_master;

    localparam int TMO = 16;

    typedef struct {
        int          lat;        // cycles from accept edge to rsp_valid cycle
        int          n_sel;      // cycles with PSEL high
        int          n_en;       // cycles with PENABLE high
        logic        proto_ok;   // SETUP then ACCESS, address/data/dir stable
        logic [31:0] pw;         // PWDATA seen during the transfer
        logic        sel_at_rsp;
        logic        rdy_at_rsp;
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } obs_t;

    logic        PCLK = 1'b0;
    logic        PRESETN;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout, busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int          n_checks = 0;
    int          n_pass   = 0;

    // slave configuration for the transfer in flight
    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] mem    [256];
    logic [31:0] shadow [256];
    logic [31:0] exp_pwdata;

    apb3_master #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Behavioural slave: works on the falling edge, ready for the k-th ACCESS
    // cycle when k == sl_waits (never when sl_waits >= TMO).
    bit   mem_init = 1'b0;
    int   acc_k    = 0;
    logic sl_hit;
    always @(negedge PCLK) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
            mem_init = 1'b1;
        end
        if (PSEL === 1'b1 && PENABLE === 1'b1) begin
            sl_hit  = (sl_waits < TMO) && (acc_k == sl_waits);
            PREADY  = sl_hit;
            PRDATA  = sl_hit ? mem[PADDR] : $urandom();
            PSLVERR = sl_hit ? sl_err : 1'b1;
            if (sl_hit && PWRITE) mem[PADDR] = PWDATA;
            acc_k++;
        end else begin
            acc_k   = 0;
            PREADY  = 1'($urandom_range(0, 1));
            PSLVERR = 1'($urandom_range(0, 1));
            PRDATA  = $urandom();
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Issue one command and observe the whole transfer up to rsp_valid.
    task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input int waits, input logic err, output obs_t o);
        int   guard;
        logic first;
        logic done;
        o.lat = 0; o.n_sel = 0; o.n_en = 0; o.proto_ok = 1'b1; o.pw = '0;
        first = 1'b1; done = 1'b0;
        @(negedge PCLK);
        sl_waits  = waits;
        sl_err    = err;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 40) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 40) begin
            n_checks++;
            $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
        end
        @(posedge PCLK);
        #1;
        // scramble the command bus so only the captured copy can be used
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = ~wdata;
        while (!done && o.lat < 40) begin
            @(negedge PCLK);
            o.lat++;
            if (rsp_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                if (PSEL === 1'b1) o.n_sel++;
                if (PENABLE === 1'b1) o.n_en++;
                if (PSEL === 1'b1) begin
                    if (first) begin
                        o.pw = PWDATA;
                        if (PENABLE !== 1'b0) o.proto_ok = 1'b0;
                    end else if (PENABLE !== 1'b1) begin
                        o.proto_ok = 1'b0;
                    end
                    first = 1'b0;
                    if (PADDR !== addr || PWRITE !== wr || PWDATA !== o.pw) o.proto_ok = 1'b0;
                end
            end
        end
        o.sel_at_rsp = PSEL;
        o.rdy_at_rsp = cmd_ready;
        o.rdata      = rsp_rdata;
        o.err        = rsp_err;
        o.tmo        = rsp_timeout;
        if (!done) begin
            n_checks++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles (addr %h)", o.lat, addr);
            o.lat = -1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge PCLK);
        n_checks++; if (PSEL !== 1'b0) $display("FAIL reset_psel: got %b want 0", PSEL); else n_pass++;
        n_checks++; if (PENABLE !== 1'b0) $display("FAIL reset_penable: got %b want 0", PENABLE); else n_pass++;
        n_checks++; if (PWRITE !== 1'b0) $display("FAIL reset_pwrite: got %b want 0", PWRITE); else n_pass++;
        n_checks++; if (PADDR !== 8'h00) $display("FAIL reset_paddr: got %h want 00", PADDR); else n_pass++;
        n_checks++; if (PWDATA !== 32'h0) $display("FAIL reset_pwdata: got %h want 0", PWDATA); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0)
            $display("FAIL reset_rsp_flags: got err=%b tmo=%b want 0/0", rsp_err, rsp_timeout); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); else n_pass++;
        PRESETN = 1'b1;
        @(negedge PCLK);
        n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL post_reset_idle: got ready=%b busy=%b want 1/0", cmd_ready, busy); else n_pass++;
    endtask

    task automatic test_write();
        obs_t o;
        run_cmd(1'b1, 8'h08, 32'hDEADBEEF, 0, 1'b0, o);
        exp_pwdata = 32'hDEADBEEF;
        shadow[8'h08] = 32'hDEADBEEF;
        n_checks++; if (o.lat !== 3) $display("FAIL write_latency: got %0d want 3", o.lat); else n_pass++;
        n_checks++; if (o.n_sel !== 2) $display("FAIL write_psel_cycles: got %0d want 2", o.n_sel); else n_pass++;
        n_checks++; if (o.n_en !== 1) $display("FAIL write_penable_cycles: got %0d want 1", o.n_en); else n_pass++;
        n_checks++; if (o.proto_ok !== 1'b1) $display("FAIL write_protocol: got %b want 1", o.proto_ok); else n_pass++;
        n_checks++; if (o.pw !== 32'hDEADBEEF) $display("FAIL write_pwdata: got %h want deadbeef", o.pw); else n_pass++;
        n_checks++; if (o.rdy_at_rsp !== 1'b1) $display("FAIL write_ready_at_rsp: got %b want 1", o.rdy_at_rsp); else n_pass++;
        n_checks++; if (o.rdata !== 32'h0 || o.err !== 1'b0 || o.tmo !== 1'b0)
            $display("FAIL write_rsp: got rdata=%h err=%b tmo=%b want 0/0/0", o.rdata, o.err, o.tmo); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL write_rsp_pulse: got %b want 0", rsp_valid); else n_pass++;
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_cmd(1'b1, 8'h10, 32'h12345678, 0, 1'b0, o);
        exp_pwdata = 32'h12345678;
        shadow[8'h10] = 32'h12345678;
        run_cmd(1'b0, 8'h10, 32'hA5A5A5A5, 3, 1'b0, o);
        n_checks++; if (o.lat !== 6) $display("FAIL read_wait_latency: got %0d want 6", o.lat); else n_pass++;
        n_checks++; if (o.n_en !== 4) $display("FAIL read_wait_access_cycles: got %0d want 4", o.n_en); else n_pass++;
        n_checks++; if (o.proto_ok !== 1'b1) $display("FAIL read_wait_protocol: got %b want 1", o.proto_ok); else n_pass++;
        n_checks++; if (o.pw !== exp_pwdata) $display("FAIL read_pwdata_held: got %h want %h", o.pw, exp_pwdata); else n_pass++;
        n_checks++; if (o.rdata !== 32'h12345678) $display("FAIL read_wait_rdata: got %h want 12345678", o.rdata); else n_pass++;
        n_checks++; if (o.err !== 1'b0 || o.tmo !== 1'b0)
            $display("FAIL read_wait_flags: got err=%b tmo=%b want 0/0", o.err, o.tmo); else n_pass++;
    endtask

    task automatic test_slverr();
        obs_t o;
        run_cmd(1'b1, 8'h24, 32'hFFFFFFFF, 0, 1'b0, o);
        exp_pwdata = 32'hFFFFFFFF;
        shadow[8'h24] = 32'hFFFFFFFF;
        run_cmd(1'b0, 8'h24, 32'h0, 2, 1'b1, o);
        n_checks++; if (o.lat !== 5) $display("FAIL slverr_latency: got %0d want 5", o.lat); else n_pass++;
        n_checks++; if (o.err !== 1'b1 || o.tmo !== 1'b0)
            $display("FAIL slverr_flags: got err=%b tmo=%b want 1/0", o.err, o.tmo); else n_pass++;
        n_checks++; if (o.rdata !== 32'hFFFFFFFF) $display("FAIL slverr_rdata: got %h want ffffffff", o.rdata); else n_pass++;
        @(negedge PCLK);
        n_checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'hFFFFFFFF || rsp_err !== 1'b1)
            $display("FAIL slverr_hold: got v=%b rdata=%h err=%b want 0/ffffffff/1", rsp_valid, rsp_rdata, rsp_err); else n_pass++;
    endtask

    task automatic test_timeout();
        obs_t o;
        run_cmd(1'b0, 8'h40, 32'h0, 16, 1'b0, o);
        n_checks++; if (o.lat !== TMO + 2) $display("FAIL timeout_latency: got %0d want %0d", o.lat, TMO + 2); else n_pass++;
        n_checks++; if (o.n_en !== TMO) $display("FAIL timeout_access_cycles: got %0d want %0d", o.n_en, TMO); else n_pass++;
        n_checks++; if (o.sel_at_rsp !== 1'b0) $display("FAIL timeout_psel_drop: got %b want 0", o.sel_at_rsp); else n_pass++;
        n_checks++; if (o.err !== 1'b1 || o.tmo !== 1'b1 || o.rdata !== 32'h0)
            $display("FAIL timeout_rsp: got err=%b tmo=%b rdata=%h want 1/1/0", o.err, o.tmo, o.rdata); else n_pass++;
        run_cmd(1'b1, 8'h44, 32'h0BAD_F00D, 0, 1'b0, o);
        exp_pwdata = 32'h0BAD_F00D;
        shadow[8'h44] = 32'h0BAD_F00D;
        n_checks++; if (o.lat !== 3 || o.tmo !== 1'b0 || o.err !== 1'b0)
            $display("FAIL after_timeout: got lat=%0d tmo=%b err=%b want 3/0/0", o.lat, o.tmo, o.err); else n_pass++;
        run_cmd(1'b0, 8'h44, 32'h0, TMO - 1, 1'b0, o);
        n_checks++; if (o.lat !== TMO + 2 || o.n_en !== TMO)
            $display("FAIL ready_at_expiry_cycles: got lat=%0d en=%0d want %0d/%0d", o.lat, o.n_en, TMO + 2, TMO); else n_pass++;
        n_checks++; if (o.tmo !== 1'b0 || o.err !== 1'b0 || o.rdata !== 32'h0BAD_F00D)
            $display("FAIL ready_at_expiry_rsp: got tmo=%b err=%b rdata=%h want 0/0/0badf00d", o.tmo, o.err, o.rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0]  addrs [4];
        logic [31:0] wd    [4];
        logic [31:0] exp_q [$];
        int cyc, idx, n_rsp, n_setup, t_first, t_last;
        addrs[0] = 8'h08; addrs[1] = 8'h0C; addrs[2] = 8'h14; addrs[3] = 8'h20;
        for (int i = 0; i < 4; i++) wd[i] = $urandom();
        cyc = 0; idx = 0; n_rsp = 0; n_setup = 0; t_first = -1; t_last = -1;
        @(negedge PCLK);
        sl_waits = 0; sl_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addrs[0]; cmd_wdata = wd[0];
        while (n_rsp < 4 && cyc < 40) begin
            if (rsp_valid === 1'b1) begin
                n_rsp++;
                t_last = cyc;
                if (exp_q.size() > 0) begin
                    n_checks++; if (rsp_rdata !== exp_q[0])
                        $display("FAIL b2b_rdata[%0d]: got %h want %h", n_rsp - 1, rsp_rdata, exp_q[0]); else n_pass++;
                    void'(exp_q.pop_front());
                end
            end
            if (PSEL === 1'b1 && PENABLE === 1'b0) begin
                if (n_setup < 4) begin
                    n_checks++; if (PADDR !== addrs[n_setup])
                        $display("FAIL b2b_paddr[%0d]: got %h want %h", n_setup, PADDR, addrs[n_setup]); else n_pass++;
                end
                n_setup++;
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                if (t_first < 0) t_first = cyc;
                if (idx % 2 == 0) begin
                    exp_q.push_back(32'h0);
                    shadow[addrs[idx]] = wd[idx];
                    exp_pwdata = wd[idx];
                end else begin
                    exp_q.push_back(shadow[addrs[idx]]);
                end
                idx++;
                @(posedge PCLK);
                #1;
                if (idx < 4) begin
                    cmd_write = (idx % 2 == 0); cmd_addr = addrs[idx]; cmd_wdata = wd[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge PCLK);
            cyc++;
        end
        n_checks++; if (n_rsp !== 4) $display("FAIL b2b_rsp_count: got %0d want 4", n_rsp); else n_pass++;
        n_checks++; if (n_setup !== 4) $display("FAIL b2b_setup_count: got %0d want 4", n_setup); else n_pass++;
        n_checks++; if (t_last - t_first !== 12) $display("FAIL b2b_total_cycles: got %0d want 12", t_last - t_first); else n_pass++;
    endtask

    task automatic test_random();
        obs_t        o;
        logic        wr, e, exp_tmo;
        logic [7:0]  a;
        logic [31:0] d, exp_rd, exp_pw;
        int          r, w, exp_lat;
        for (int t = 0; t < 30; t++) begin
            wr = 1'($urandom_range(0, 1));
            e  = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 15) * 4);
            d  = $urandom();
            r  = $urandom_range(0, 9);
            w  = (r < 6) ? r % 4 : (r == 6) ? TMO - 1 : TMO + r % 3;
            exp_tmo = (w >= TMO);
            exp_lat = exp_tmo ? TMO + 2 : w + 3;
            exp_rd  = (wr || exp_tmo) ? 32'h0 : shadow[a];
            exp_pw  = wr ? d : exp_pwdata;
            run_cmd(wr, a, d, w, e, o);
            exp_pwdata = exp_pw;
            if (wr && !exp_tmo) shadow[a] = d;
            n_checks++; if (o.lat !== exp_lat) $display("FAIL rand[%0d]_latency: got %0d want %0d", t, o.lat, exp_lat); else n_pass++;
            n_checks++; if (o.n_sel !== exp_lat - 1) $display("FAIL rand[%0d]_psel_cycles: got %0d want %0d", t, o.n_sel, exp_lat - 1); else n_pass++;
            n_checks++; if (o.n_en !== exp_lat - 2) $display("FAIL rand[%0d]_penable_cycles: got %0d want %0d", t, o.n_en, exp_lat - 2); else n_pass++;
            n_checks++; if (o.proto_ok !== 1'b1) $display("FAIL rand[%0d]_protocol: got %b want 1", t, o.proto_ok); else n_pass++;
            n_checks++; if (o.pw !== exp_pw) $display("FAIL rand[%0d]_pwdata: got %h want %h", t, o.pw, exp_pw); else n_pass++;
            n_checks++; if (o.sel_at_rsp !== 1'b0 || o.rdy_at_rsp !== 1'b1)
                $display("FAIL rand[%0d]_idle_at_rsp: got sel=%b rdy=%b want 0/1", t, o.sel_at_rsp, o.rdy_at_rsp); else n_pass++;
            n_checks++; if (o.rdata !== exp_rd) $display("FAIL rand[%0d]_rdata: got %h want %h", t, o.rdata, exp_rd); else n_pass++;
            n_checks++; if (o.err !== (exp_tmo | e)) $display("FAIL rand[%0d]_err: got %b want %b", t, o.err, exp_tmo | e); else n_pass++;
            n_checks++; if (o.tmo !== exp_tmo) $display("FAIL rand[%0d]_timeout: got %b want %b", t, o.tmo, exp_tmo); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   seen, bad;
        @(negedge PCLK);
        sl_waits = TMO + 4; sl_err = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h30; cmd_wdata = 32'h5555AAAA;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        repeat (4) @(negedge PCLK);
        n_checks++; if (PENABLE !== 1'b1 || busy !== 1'b1)
            $display("FAIL mid_in_access: got en=%b busy=%b want 1/1", PENABLE, busy); else n_pass++;
        #2;
        PRESETN = 1'b0;
        #1;
        n_checks++; if (PSEL !== 1'b0 || PENABLE !== 1'b0)
            $display("FAIL mid_reset_bus: got sel=%b en=%b want 0/0", PSEL, PENABLE); else n_pass++;
        n_checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0)
            $display("FAIL mid_reset_status: got busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); else n_pass++;
        exp_pwdata = 32'h0;
        @(negedge PCLK);
        PRESETN = 1'b1;
        seen = 0; bad = 0;
        repeat (25) begin
            @(negedge PCLK);
            if (rsp_valid !== 1'b0) seen++;
            if (cmd_ready !== 1'b1) bad++;
        end
        n_checks++; if (seen !== 0) $display("FAIL mid_stale_rsp: got %0d pulses want 0", seen); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL mid_cmd_ready: got %0d not-ready cycles want 0", bad); else n_pass++;
        run_cmd(1'b0, 8'h30, 32'h0, 1, 1'b0, o);
        n_checks++; if (o.lat !== 4 || o.rdata !== shadow[8'h30])
            $display("FAIL mid_recover: got lat=%0d rdata=%h want 4/%h", o.lat, o.rdata, shadow[8'h30]); else n_pass++;
        n_checks++; if (o.pw !== exp_pwdata) $display("FAIL mid_pwdata_reset: got %h want %h", o.pw, exp_pwdata); else n_pass++;
    endtask

    initial begin
        PRESETN   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        exp_pwdata = 32'h0;
        for (int i = 0; i < 256; i++) shadow[i] = 32'hC0DE_0000 | 32'(i);
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
